// File: rtl/id_pkg.sv
// Shared constants for the decode stage: MIPS opcode/funct encodings,
// the nop word, instruction field positions and a sign-extend helper.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [31:0] NOP = 32'h0;

    // Instruction field positions
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bus between fetch, write-back and the decode stage.
// master: the surrounding pipeline (drives fetch/wb/hazard inputs).
// slave:  id_stage.
interface id_stage_if #(
    parameter int PC_W = 10
);
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            stall;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [31:0]     wb_data;
    logic [31:0]     id_instr;
    logic [PC_W-1:0] id_pc;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;
    logic [31:0]     imm_ext;
    logic            pc_branch;
    logic            pc_jump;
    logic            reg_to_pc;
    logic [31:0]     reg_topc_val;

    modport master (
        output if_instr, if_pc, stall, flush, wb_we, wb_addr, wb_data,
        input  id_instr, id_pc, rs_data, rt_data, imm_ext,
               pc_branch, pc_jump, reg_to_pc, reg_topc_val
    );

    modport slave (
        input  if_instr, if_pc, stall, flush, wb_we, wb_addr, wb_data,
        output id_instr, id_pc, rs_data, rt_data, imm_ext,
               pc_branch, pc_jump, reg_to_pc, reg_topc_val
    );
endinterface

// File: rtl/id_stage_grf.sv
// General register file: two combinational read ports, one write port,
// synchronous clear, register 0 hardwired to zero.
// Optional macro ID_WB_BYPASS_EN: same-cycle write-through to the read ports.
module grf #(
    parameter int REG_CNT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [REG_CNT-1:0][31:0] regs;
    logic                     wr_ok;

    // A write is real only for a nonzero target; reset takes precedence.
    assign wr_ok = we && (waddr != 5'd0);

    // Storage: clear on reset, otherwise commit write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef ID_WB_BYPASS_EN
    // Read ports with write-through so a dependent instruction in ID sees
    // the value being written this cycle.
    always_comb begin
        rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
        rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];
        if (!reset && wr_ok && (waddr == ra1)) rd1 = wdata;
        if (!reset && wr_ok && (waddr == ra2)) rd2 = wdata;
    end
`else
    // Read ports return stored values only; a new value appears after the
    // write edge.
    always_comb begin
        rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
        rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];
    end
`endif

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register (reset > flush > stall > load), GRF reads,
// immediate extension and early resolution of beq/j/jal/jr.
// Optional macro ID_WB_BYPASS_EN enables GRF write-through (see grf).
module id_stage
    import id_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              REG_CNT  = 32
) (
    input  logic      clk,
    input  logic      reset,
    id_stage_if.slave bus
);

    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [31:0]     rs_val;
    logic [31:0]     rt_val;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            br_taken;
    logic            jump;
    logic            jr;

    // IF/ID pipeline register; flush beats stall, flush keeps the PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= NOP;
            pc    <= RESET_PC;
        end else if (bus.flush) begin
            instr <= NOP;
        end else if (!bus.stall) begin
            instr <= bus.if_instr;
            pc    <= bus.if_pc;
        end
    end

    grf #(.REG_CNT(REG_CNT)) u_grf (
        .clk   (clk),
        .reset (reset),
        .we    (bus.wb_we),
        .waddr (bus.wb_addr),
        .wdata (bus.wb_data),
        .ra1   (instr[RS_HI:RS_LO]),
        .ra2   (instr[RT_HI:RT_LO]),
        .rd1   (rs_val),
        .rd2   (rt_val)
    );

    assign opcode = instr[OP_HI:OP_LO];
    assign funct  = instr[FN_HI:FN_LO];

    // Redirect decode; the nop and all other opcodes leave every flag low.
    always_comb begin
        br_taken = 1'b0;
        jump     = 1'b0;
        jr       = 1'b0;
        case (opcode)
            OP_BEQ:      br_taken = (rs_val == rt_val);
            OP_J,
            OP_JAL:      jump = 1'b1;
            OP_RTYPE:    jr = (funct == FN_JR);
            default:     ;
        endcase
    end

    assign bus.id_instr     = instr;
    assign bus.id_pc        = pc;
    assign bus.rs_data      = rs_val;
    assign bus.rt_data      = rt_val;
    assign bus.imm_ext      = sext16(instr[IMM_HI:IMM_LO]);
    assign bus.pc_branch    = br_taken;
    assign bus.pc_jump      = jump;
    assign bus.reg_to_pc    = jr;
    assign bus.reg_topc_val = rs_val;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage directly downstream of the instruction fetch unit.
- Latches the fetched instruction and word PC into an IF/ID pipeline register, with stall, flush and reset.
- Holds the 32x32 general register file (GRF), which is read in ID and written from write-back.
- Resolves beq, j, jal and jr in ID, and returns the redirect controls and the jr target to the fetch unit.

Parameters:
- PC_W, 10, width of the word PC (byte address bits [11:2]).
- RESET_PC, 10'h000, value of id_pc after reset.
- REG_CNT, 32, number of GRF registers; register 0 is hardwired to zero.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_instr  in  32  instruction from the fetch unit
- if_pc  in  PC_W  word PC of if_instr
- stall  in  1  hold the IF/ID register (from the hazard unit)
- flush  in  1  load a bubble into the IF/ID register
- wb_we  in  1  GRF write enable
- wb_addr  in  5  GRF write address
- wb_data  in  32  GRF write data
- id_instr  out  32  latched instruction
- id_pc  out  PC_W  latched PC
- rs_data  out  32  GRF[id_instr[25:21]]
- rt_data  out  32  GRF[id_instr[20:16]]
- imm_ext  out  32  sign-extended id_instr[15:0]
- pc_branch  out  1  beq taken
- pc_jump  out  1  j or jal
- reg_to_pc  out  1  jr
- reg_topc_val  out  32  jr target (equals rs_data)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- IF/ID register update on posedge clk, highest priority first:
  - reset: id_instr=32'h0 (nop), id_pc=RESET_PC.
  - flush: id_instr=32'h0, id_pc unchanged.
  - stall: hold both fields.
  - otherwise: load if_instr and if_pc.
- Simultaneous flush and stall: flush wins.
- GRF reset: all registers cleared to 0 on reset. A write on the same edge as reset is dropped.
- GRF write: on posedge clk when wb_we=1 and wb_addr!=0. Writes to register 0 are ignored and it always reads 0.
- GRF read: combinational from the id_instr fields, so there is zero cycles of latency from id_instr.
- imm_ext: {{16{id_instr[15]}}, id_instr[15:0]}.
- Decode (combinational, from id_instr; all flags are 0 otherwise, including the nop):
  - opcode 6'b000100 (beq): pc_branch = (rs_data == rt_data).
  - opcode 6'b000010 (j) or 6'b000011 (jal): pc_jump = 1.
  - opcode 0 with funct 6'b001000 (jr): reg_to_pc = 1.
- Branch delay slot architecture: ID never flushes itself on a redirect; only the flush input does.
- All outputs are 0 during reset and in the first cycle after reset. Exception: id_pc, which equals RESET_PC.
- Stall held for many cycles: outputs stay stable, while GRF writes still complete.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: write-through bypass. When wb_we=1, wb_addr!=0 and wb_addr equals the rs or rt field, rs_data/rt_data (and the branch compare) take wb_data in the same cycle.
- Undefined: reads return the stored value only. The new value is visible the cycle after the write edge, and the hazard unit must stall one extra cycle.

Decomposition:
- Package id_pkg holds:
  - opcode constants OP_RTYPE, OP_BEQ, OP_J, OP_JAL;
  - funct constant FN_JR;
  - the NOP constant 32'h0;
  - the field-slice positions.
- Sub-module grf: the register file with reset clear, zero register, and the optional bypass.
- id_stage holds the IF/ID register, the decode logic and the compare.

Test Plan:
- Reset: reset=1 for 2 cycles with if_instr=32'h1234_5678 -> id_instr=0, id_pc=0, all flags 0, rs_data=rt_data=0.
- Capture and stall:
  - Load if_instr=32'h8C01_0004, if_pc=10'h004 -> next cycle id_instr=32'h8C01_0004, id_pc=10'h004.
  - stall=1 with new inputs -> values held.
- Flush precedence: stall=1 and flush=1 together -> id_instr=0 next cycle, id_pc held.
- GRF write and zero register:
  - Write reg 5 = 32'hDEAD_BEEF, then decode 32'h00A0_0008 (jr $5) -> reg_to_pc=1, reg_topc_val=32'hDEAD_BEEF.
  - A write to reg 0 leaves reads of reg 0 at 0.
- beq:
  - reg1=reg2=7, id_instr=32'h1022_0003 -> pc_branch=1, imm_ext=3.
  - Change reg2 to 8 -> pc_branch=0.
  - imm 16'hFFFF -> imm_ext=32'hFFFF_FFFF.
- Bypass (ID_WB_BYPASS_EN defined vs undefined):
  - Stimulus: id_instr=jr $5 with a same-cycle wb_we to reg 5 of 32'h0000_1000.
  - Defined: reg_topc_val=32'h0000_1000 in that cycle.
  - Undefined: old value in that cycle, new value on the next cycle.
